// File: rtl/usb_pkg.sv
// usb_pkg: shared full-speed USB transmit types and line-state constants
package usb_pkg;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} tx_state_t;
    localparam logic [7:0] USB_SYNC = 8'h80;
    localparam logic [1:0] LS_J = 2'b10;
    localparam logic [1:0] LS_K = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam int STUFF_LIMIT = 6;
endpackage

// File: rtl/usb_nrzi_stuffer.sv
// usb_nrzi_stuffer: NRZI encoder with run-of-ones tracking, advanced once per bit strobe
module usb_nrzi_stuffer
    import usb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_stb,
    input  logic bit_init,
    input  logic bit_in,
    output logic stuff_req,
    output logic nrzi_d
);
    logic nrzi_q;
    logic [2:0] ones_q, ones_d;
    logic base_lvl, toggle;
    logic [2:0] base_ones;

    assign stuff_req = ones_q == 3'(STUFF_LIMIT);

    // bit_init restarts from J with an empty run, so a packet never inherits stale state
    always_comb begin
        base_lvl = bit_init ? 1'b1 : nrzi_q;
        base_ones = bit_init ? 3'd0 : ones_q;
        toggle = (stuff_req && !bit_init) || !bit_in;
        nrzi_d = bit_stb ? base_lvl ^ toggle : nrzi_q;
        ones_d = bit_stb ? (toggle ? 3'd0 : base_ones + 3'd1) : ones_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nrzi_q <= 1'b1;
            ones_q <= 3'd0;
        end else begin
            nrzi_q <= nrzi_d;
            ones_q <= ones_d;
        end
    end
endmodule

// File: rtl/usb_fs_tx_serializer.sv
// usb_fs_tx_serializer: full-speed USB transmit path, bytes in, SYNC/stuffed NRZI/EOP out on D+/D-
module usb_fs_tx_serializer
    import usb_pkg::*;
#(
    parameter int CLK_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_underrun,
    output logic       usb_dp,
    output logic       usb_dn,
    output logic       usb_oe
);
    localparam int PW = $clog2(CLK_PER_BIT);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_BIT - 1);

    tx_state_t state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic last_q, last_d;
    logic [1:0] line_q, line_d, eop_line;
    logic oe_q, oe_d, und_q, und_d;
    logic bit_end, boundary, stb, init, bit_val, stuff_req, nrzi_d;

    usb_nrzi_stuffer u_nrzi (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_stb  (stb),
        .bit_init (init),
        .bit_in   (bit_val),
        .stuff_req(stuff_req),
        .nrzi_d   (nrzi_d)
    );

    assign bit_end = phase_q == PH_LAST;
    assign boundary = state_q == DATA && bit_end && bit_q == 3'd7 && !stuff_req;
    assign tx_ready = rst_n && (state_q == IDLE || (boundary && !last_q));
    assign tx_busy = state_q != IDLE;
    assign tx_underrun = und_q;
    assign {usb_dp, usb_dn} = line_q;
    assign usb_oe = oe_q;
    assign line_d = stb ? (nrzi_d ? LS_J : LS_K) : eop_line;

    // bit_q indexes SYNC bits, then data bits of the current byte, then EOP SE0 bit times
    always_comb begin
        state_d = state_q;
        phase_d = (state_q == IDLE || bit_end) ? '0 : phase_q + 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        last_d = last_q;
        oe_d = oe_q;
        und_d = 1'b0;
        eop_line = line_q;
        stb = 1'b0;
        init = 1'b0;
        bit_val = 1'b0;
        case (state_q)
            IDLE: if (tx_valid) begin
                state_d = SYNC;
                stb = 1'b1;
                init = 1'b1;
                bit_val = USB_SYNC[0];
                bit_d = 3'd0;
                shift_d = tx_data;
                last_d = tx_last;
                oe_d = 1'b1;
            end
            SYNC: if (bit_end) begin
                stb = 1'b1;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = DATA;
                    bit_val = shift_q[0];
                    shift_d = shift_q >> 1;
                end else begin
                    bit_val = USB_SYNC[bit_q + 3'd1];
                end
            end
            DATA: if (boundary) begin
                if (tx_valid && !last_q) begin
                    stb = 1'b1;
                    bit_val = tx_data[0];
                    shift_d = {1'b0, tx_data[7:1]};
                    last_d = tx_last;
                    bit_d = 3'd0;
                end else begin
                    state_d = EOP_SE0;
                    eop_line = LS_SE0;
                    bit_d = 3'd0;
                    und_d = !last_q;
                end
            end else if (bit_end) begin
                stb = 1'b1;
                bit_val = shift_q[0];
                if (!stuff_req) begin
                    shift_d = shift_q >> 1;
                    bit_d = bit_q + 3'd1;
                end
            end
            EOP_SE0: if (bit_end) begin
                bit_d = bit_q + 3'd1;
                if (bit_q[0]) begin
                    state_d = EOP_J;
                    eop_line = LS_J;
                end
            end
            EOP_J: if (bit_end) begin
                state_d = IDLE;
                oe_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            bit_q <= 3'd0;
            shift_q <= 8'd0;
            last_q <= 1'b0;
            line_q <= LS_J;
            oe_q <= 1'b0;
            und_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            last_q <= last_d;
            line_q <= line_d;
            oe_q <= oe_d;
            und_q <= und_d;
        end
    end
endmodule

// File: tb/tb_usb_fs_tx_serializer.sv
// tb_usb_fs_tx_serializer: table, hand-written and random packets checked against a bit-list line model
module tb_usb_fs_tx_serializer;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n, tx_valid, tx_last, tx_ready, tx_busy, tx_underrun, usb_dp, usb_dn, usb_oe;
    logic [7:0] tx_data;

    typedef struct {
        logic [23:0] bytes;
        int n;
        int drop;
        int bits;
        int rdy;
        int und;
    } vec_t;

    vec_t vecs[8];
    logic [7:0] pkt[$];
    logic [1:0] line_q[$];
    logic [1:0] exp_q[$];
    int tests = 0, fails = 0;
    int rdy_cnt, und_cnt, und_pos, busy_bad, idle_bad, se0_sym;

    usb_fs_tx_serializer #(.CLK_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_underrun(tx_underrun),
        .usb_dp     (usb_dp),
        .usb_dn     (usb_dn),
        .usb_oe     (usb_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        line_q.delete();
        rdy_cnt = 0;
        und_cnt = 0;
        und_pos = 0;
        busy_bad = 0;
        idle_bad = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (usb_oe) line_q.push_back({usb_dp, usb_dn});
        if (tx_ready && tx_busy) rdy_cnt++;
        if (tx_underrun) begin
            und_cnt++;
            und_pos = line_q.size();
        end
        if (tx_busy != usb_oe) busy_bad++;
        if (!usb_oe && {usb_dp, usb_dn} != 2'b10) idle_bad++;
    endtask

    task automatic push_sym(input logic [1:0] s);
        repeat (CPB) exp_q.push_back(s);
    endtask

    // Expected line: SYNC then bytes LSB first, a toggle after every six 1s, NRZI from J, then SE0 SE0 J
    task automatic model(input int nb);
        logic [7:0] cur;
        logic lvl;
        int ones;
        exp_q.delete();
        lvl = 1'b1;
        ones = 0;
        for (int i = 0; i < 8 + 8 * nb; i++) begin
            if (i < 8) cur = 8'h80;
            else cur = pkt[i / 8 - 1];
            if (!cur[i % 8]) begin
                lvl = ~lvl;
                ones = 0;
            end else begin
                ones++;
            end
            push_sym(lvl ? 2'b10 : 2'b01);
            if (ones == 6) begin
                lvl = ~lvl;
                ones = 0;
                push_sym(lvl ? 2'b10 : 2'b01);
            end
        end
        se0_sym = exp_q.size() / CPB;
        push_sym(2'b00);
        push_sym(2'b00);
        push_sym(2'b10);
    endtask

    task automatic compare_line();
        int bad;
        bad = 0;
        check("line_len", line_q.size(), exp_q.size());
        for (int i = 0; i < line_q.size() && i < exp_q.size(); i++)
            if (line_q[i] !== exp_q[i]) bad++;
        check("line_mismatched_samples", bad, 0);
    endtask

    // Drives one packet; while tx_ready is low the inputs carry junk that must be ignored
    task automatic send(input int drop);
        int n, lim, idx, cyc;
        bit started, done;
        n = pkt.size();
        lim = drop != 0 ? drop : n;
        idx = 0;
        cyc = 0;
        started = 0;
        done = 0;
        clear_mon();
        while (!done && cyc < 4000) begin
            tick();
            cyc++;
            if (tx_busy) started = 1;
            if (idx == lim && started && !tx_busy) begin
                done = 1;
                tx_valid = 1'b0;
            end else if (tx_ready) begin
                if (idx < lim) begin
                    tx_valid = 1'b1;
                    tx_data = pkt[idx];
                    tx_last = idx == n - 1;
                    idx++;
                end else begin
                    tx_valid = 1'b0;
                    tx_data = 8'($urandom);
                    tx_last = 1'($urandom);
                end
            end else begin
                tx_valid = 1'($urandom);
                tx_data = 8'($urandom);
                tx_last = 1'($urandom);
            end
        end
        tx_valid = 1'b0;
        check("send_complete", int'(done), 1);
    endtask

    task automatic verify(input int drop);
        int lim;
        lim = drop != 0 ? drop : pkt.size();
        model(lim);
        compare_line();
        check("ready_pulses", rdy_cnt, drop != 0 ? lim : lim - 1);
        check("underrun_pulses", und_cnt, drop != 0 ? 1 : 0);
        if (drop != 0) check("underrun_pos", und_pos, se0_sym * CPB + 1);
        check("busy_tracks_oe", busy_bad, 0);
        check("idle_line_j", idle_bad, 0);
    endtask

    initial begin
        logic [23:0] tmp;
        int cyc, gap, n, drop;
        bit seen;
        vecs[0] = '{24'h0000D2, 1, 0, 19, 0, 0};
        vecs[1] = '{24'h0000FF, 1, 0, 20, 0, 0};
        vecs[2] = '{24'h02014B, 3, 0, 35, 2, 0};
        vecs[3] = '{24'h0055C3, 2, 1, 19, 1, 1};
        vecs[4] = '{24'h00FFFF, 2, 0, 29, 1, 0};
        vecs[5] = '{24'h0000FC, 1, 0, 20, 0, 0};
        vecs[6] = '{24'h0000FC, 2, 0, 28, 1, 0};
        vecs[7] = '{24'h0055FC, 2, 1, 20, 1, 1};

        rst_n = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        tx_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_oe", usb_oe, 0);
        check("rst_dp", usb_dp, 1);
        check("rst_dn", usb_dn, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_underrun", tx_underrun, 0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", tx_ready, 1);
        check("idle_busy", tx_busy, 0);

        for (int i = 0; i < 8; i++) begin
            pkt.delete();
            tmp = vecs[i].bytes;
            for (int j = 0; j < vecs[i].n; j++) pkt.push_back(tmp[8 * j +: 8]);
            send(vecs[i].drop);
            verify(vecs[i].drop);
            check("tbl_oe_clks", line_q.size(), vecs[i].bits * CPB);
            check("tbl_ready", rdy_cnt, vecs[i].rdy);
            check("tbl_underrun", und_cnt, vecs[i].und);
        end

        // tx_valid held through EOP: next SYNC must follow a single idle clock
        pkt.delete();
        pkt.push_back(8'hFF);
        clear_mon();
        tx_valid = 1'b1;
        tx_data = 8'hFF;
        tx_last = 1'b1;
        cyc = 0;
        seen = 0;
        while (cyc < 1000 && !(seen && !usb_oe)) begin
            tick();
            cyc++;
            if (usb_oe) seen = 1;
        end
        gap = 0;
        while (cyc < 1000 && !usb_oe) begin
            gap++;
            tick();
            cyc++;
        end
        check("eop_gap_clks", gap, 1);
        tx_valid = 1'b0;
        while (cyc < 1000 && tx_busy) begin
            tick();
            cyc++;
        end
        check("b2b_done", tx_busy, 0);
        model(1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_q[i]);
        compare_line();
        check("b2b_ready", rdy_cnt, 0);
        check("b2b_underrun", und_cnt, 0);

        // reset in the second data byte, then a clean packet
        clear_mon();
        tx_valid = 1'b1;
        tx_data = 8'h11;
        tx_last = 1'b0;
        repeat (20 * CPB) tick();
        check("mid_busy", tx_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_oe", usb_oe, 0);
        check("mid_rst_dp", usb_dp, 1);
        check("mid_rst_dn", usb_dn, 0);
        check("mid_rst_ready", tx_ready, 0);
        check("mid_rst_busy", tx_busy, 0);
        tx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        pkt.delete();
        pkt.push_back(8'hD2);
        send(0);
        verify(0);

        for (int r = 0; r < 20; r++) begin
            n = $urandom_range(1, 4);
            pkt.delete();
            for (int j = 0; j < n; j++)
                pkt.push_back($urandom_range(0, 1) != 0 ? 8'($urandom) : 8'hFF ^ (8'd1 << $urandom_range(0, 7)));
            drop = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
            send(drop);
            verify(drop);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
